// File: rtl/mem_pkg.sv
// Shared types and constants for the cache-side memory controller.
package mem_pkg;

  localparam int ADDR_WIDTH = 18;

  // addr[ADDR_WIDTH-1:ADDR_WIDTH-2] value that selects IO space
  localparam logic [1:0] IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IC   = 2'd1,
    GNT_DC   = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache-side request ports plus the RAM/IO byte bus of mem_ctrl.
interface mem_ctrl_if import mem_pkg::*; #(
  parameter int AW = ADDR_WIDTH
) ();

  logic          hci_rdy;
  logic          io_buffer_full;

  logic          dc_get_en;
  logic          dc_write_mode;
  logic [AW-1:0] dc_addr;
  logic [7:0]    dc_data;
  logic          dc_out_en;
  logic [7:0]    dc_content;

  logic          ic_get_en;
  logic [AW-1:0] ic_addr;
  logic          ic_out_en;
  logic [7:0]    ic_content;

  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  modport slave (
    input  hci_rdy, io_buffer_full,
    input  dc_get_en, dc_write_mode, dc_addr, dc_data,
    output dc_out_en, dc_content,
    input  ic_get_en, ic_addr,
    output ic_out_en, ic_content,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output hci_rdy, io_buffer_full,
    output dc_get_en, dc_write_mode, dc_addr, dc_data,
    input  dc_out_en, dc_content,
    output ic_get_en, ic_addr,
    input  ic_out_en, ic_content,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_port_mux.sv
// Combinational grant (dcache over icache) and RAM/IO bus drive.
// With MEM_CTRL_IO_GUARD_EN defined, IO writes wait while the IO buffer is full.
module mem_port_mux import mem_pkg::*; #(
  parameter int AW = ADDR_WIDTH
) (
  input  logic          i_en,
  input  logic          i_dc_get_en,
  input  logic          i_dc_write_mode,
  input  logic [AW-1:0] i_dc_addr,
  input  logic [7:0]    i_dc_data,
  input  logic          i_ic_get_en,
  input  logic [AW-1:0] i_ic_addr,
  input  logic          i_io_buffer_full,
  input  logic [AW-1:0] i_mem_a_hold,
  output grant_t        o_grant,
  output logic [AW-1:0] o_mem_a,
  output logic          o_mem_wr,
  output logic [7:0]    o_mem_dout
);

  logic w_dc_blocked;

`ifdef MEM_CTRL_IO_GUARD_EN
  assign w_dc_blocked = i_dc_write_mode && i_io_buffer_full &&
                        (i_dc_addr[AW-1 -: 2] == IO_PREFIX);
`else
  logic w_unused_io_full;
  assign w_unused_io_full = i_io_buffer_full;
  assign w_dc_blocked     = 1'b0;
`endif

  // Without a grant the address is held so the RAM keeps re-reading the same byte.
  always_comb begin
    o_grant    = GNT_NONE;
    o_mem_a    = i_mem_a_hold;
    o_mem_wr   = 1'b0;
    o_mem_dout = 8'h00;
    if (i_en) begin
      if (i_dc_get_en && !w_dc_blocked) begin
        o_grant    = GNT_DC;
        o_mem_a    = i_dc_addr;
        o_mem_wr   = i_dc_write_mode;
        o_mem_dout = i_dc_data;
      end else if (i_ic_get_en) begin
        o_grant    = GNT_IC;
        o_mem_a    = i_ic_addr;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory responder: one ack per accepted byte, one active cycle later.
// Optional IO write guard enabled by defining MEM_CTRL_IO_GUARD_EN.
//
//   state    | meaning
//   GNT_NONE | no byte accepted last active cycle, no ack due
//   GNT_IC   | icache byte accepted, ack due on next hci_rdy cycle
//   GNT_DC   | dcache byte accepted, ack due on next hci_rdy cycle
module mem_ctrl import mem_pkg::*; #(
  parameter int AW = ADDR_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  grant_t        w_grant;
  grant_t        w_grant_d;
  grant_t        r_grant_q;
  logic          w_mem_wr;
  logic          w_wr_d;
  logic          r_wr_q;
  logic [AW-1:0] w_mem_a;
  logic [AW-1:0] r_mem_a;
  logic [7:0]    w_mem_dout;
  logic          w_dc_ack;
  logic          w_ic_ack;

  mem_port_mux #(.AW(AW)) u_mux (
    .i_en             (bus.hci_rdy && rst),
    .i_dc_get_en      (bus.dc_get_en),
    .i_dc_write_mode  (bus.dc_write_mode),
    .i_dc_addr        (bus.dc_addr),
    .i_dc_data        (bus.dc_data),
    .i_ic_get_en      (bus.ic_get_en),
    .i_ic_addr        (bus.ic_addr),
    .i_io_buffer_full (bus.io_buffer_full),
    .i_mem_a_hold     (r_mem_a),
    .o_grant          (w_grant),
    .o_mem_a          (w_mem_a),
    .o_mem_wr         (w_mem_wr),
    .o_mem_dout       (w_mem_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant_q <= GNT_NONE;
      r_wr_q    <= 1'b0;
      r_mem_a   <= '0;
    end else begin
      r_grant_q <= w_grant_d;
      r_wr_q    <= w_wr_d;
      r_mem_a   <= w_mem_a;
    end
  end

  // A stalled bus freezes the pending ack until hci_rdy returns.
  always_comb begin
    w_grant_d = r_grant_q;
    w_wr_d    = r_wr_q;
    if (bus.hci_rdy) begin
      w_grant_d = w_grant;
      w_wr_d    = w_mem_wr;
    end
  end

  assign w_dc_ack = bus.hci_rdy && (r_grant_q == GNT_DC);
  assign w_ic_ack = bus.hci_rdy && (r_grant_q == GNT_IC);

  assign bus.mem_a      = w_mem_a;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.mem_dout   = w_mem_dout;
  assign bus.dc_out_en  = w_dc_ack;
  assign bus.ic_out_en  = w_ic_ack;
  assign bus.dc_content = (w_dc_ack && !r_wr_q) ? bus.mem_din : 8'h00;
  assign bus.ic_content = w_ic_ack ? bus.mem_din : 8'h00;

endmodule
